// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: PC generator, registered-ROM request engine,
// DEPTH-entry prefetch queue and valid/ready handoff to decode.
module fetch_prefetch_queue #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 10,
  parameter int DEPTH = 4,
  parameter logic [ADDR_SIZE+1:0] RESET_PC = '0
) (
  input  logic                         CLK,
  input  logic                         RESET,
  output logic [ADDR_SIZE-1:0]         iaddr,
  output logic                         ireq,
  input  logic [DATA_SIZE-1:0]         idata,
  input  logic                         redirect,
  input  logic [ADDR_SIZE+1:0]         redirect_pc,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [DATA_SIZE-1:0]         inst,
  output logic [ADDR_SIZE+1:0]         inst_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW   = ADDR_SIZE + 2;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PTRW = $clog2(DEPTH);
  localparam logic [ADDR_SIZE-1:0] RESET_WORD = RESET_PC[PW-1:2];

  logic [PW-1:0]        fetch_pc;
  logic [PW-1:0]        pc_q;
  logic                 inflight_q;
  logic [CW-1:0]        count_q;
  logic [PTRW-1:0]      rd_ptr;
  logic [PTRW-1:0]      wr_ptr;
  logic [DATA_SIZE-1:0] data_mem [DEPTH];
  logic [PW-1:0]        pc_mem   [DEPTH];

  logic                 pop;
  logic                 push;
  logic [CW:0]          occupancy;

  // Issue only when the in-flight slot is guaranteed a free queue entry,
  // counting the entry decode frees this cycle.
  always_comb begin
    inst_valid = !RESET && (count_q != '0);
    pop        = inst_valid && inst_ready;
    occupancy  = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    ireq       = !RESET && !redirect && (occupancy < (CW+1)'(DEPTH));
    push       = !RESET && !redirect && inflight_q;
    iaddr      = RESET ? RESET_WORD : fetch_pc[PW-1:2];
    count      = RESET ? '0 : count_q;
    inst       = inst_valid ? data_mem[rd_ptr] : '0;
    inst_pc    = inst_valid ? pc_mem[rd_ptr] : '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_pc   <= RESET_PC;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else if (redirect) begin
      fetch_pc   <= redirect_pc & ~PW'(3);
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      if (ireq) begin
        fetch_pc   <= fetch_pc + PW'(4);
        pc_q       <= fetch_pc;
        inflight_q <= 1'b1;
      end else begin
        inflight_q <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      data_mem[wr_ptr] <= idata;
      pc_mem[wr_ptr]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue; the ROM model returns word n = n.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  iaddr;
  logic        ireq;
  logic [31:0] idata = '0;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [11:0] inst_pc;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  fetch_prefetch_queue #(
    .DATA_SIZE(32), .ADDR_SIZE(10), .DEPTH(4), .RESET_PC(12'h000)
  ) dut (
    .CLK(clk), .RESET(reset), .iaddr(iaddr), .ireq(ireq), .idata(idata),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .count(count)
  );

  always #5 clk = ~clk;

  // Registered ROM: data for the requested word appears the next cycle.
  always @(posedge clk) if (ireq) idata <= 32'(iaddr);

  // One cycle: drive at the falling edge, then settle before checking.
  task automatic apply_stimulus(input logic rst, input logic rdy,
                                input logic redir, input logic [11:0] rpc);
    @(negedge clk);
    reset = rst; inst_ready = rdy; redirect = redir; redirect_pc = rpc;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;

    // Reset state
    repeat (2) apply_stimulus(1, 1, 0, 0);
    check_output("rst_ireq", 32'(ireq), 0);
    check_output("rst_valid", 32'(inst_valid), 0);
    check_output("rst_count", 32'(count), 0);
    check_output("rst_iaddr", 32'(iaddr), 0);
    check_output("rst_inst", inst, 0);
    check_output("rst_pc", 32'(inst_pc), 0);

    // Cold start
    apply_stimulus(0, 1, 0, 0);
    check_output("cold_c0_ireq", 32'(ireq), 1);
    check_output("cold_c0_iaddr", 32'(iaddr), 0);
    check_output("cold_c0_valid", 32'(inst_valid), 0);
    apply_stimulus(0, 1, 0, 0);
    check_output("cold_c1_valid", 32'(inst_valid), 0);
    check_output("cold_c1_iaddr", 32'(iaddr), 1);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(0, 1, 0, 0);
      check_output("cold_valid", 32'(inst_valid), 1);
      check_output("cold_inst", inst, 32'(k));
      check_output("cold_pc", 32'(inst_pc), 32'(4 * k));
      check_output("cold_count", 32'(count), 1);
    end

    // Backpressure from cycle 0
    apply_stimulus(1, 0, 0, 0);
    for (int c = 0; c < 7; c++) begin
      apply_stimulus(0, 0, 0, 0);
      check_output("bp_ireq", 32'(ireq), (c < 4) ? 1 : 0);
      check_output("bp_count", 32'(count), (c < 5) ? ((c < 2) ? 0 : c - 1) : 4);
    end
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(0, 1, 0, 0);
      if (k == 0) begin
        check_output("bp_release_ireq", 32'(ireq), 1);
        check_output("bp_release_iaddr", 32'(iaddr), 4);
      end
      check_output("bp_drain_valid", 32'(inst_valid), 1);
      check_output("bp_drain_inst", inst, 32'(k));
    end

    // Redirect with three queued and one in flight
    apply_stimulus(0, 1, 1, 12'h100);
    check_output("rd1_count", 32'(count), 3);
    check_output("rd1_ireq", 32'(ireq), 0);
    apply_stimulus(0, 1, 0, 0);
    check_output("rd1_t1_count", 32'(count), 0);
    check_output("rd1_t1_valid", 32'(inst_valid), 0);
    check_output("rd1_t1_ireq", 32'(ireq), 1);
    check_output("rd1_t1_iaddr", 32'(iaddr), 32'h40);
    apply_stimulus(0, 1, 0, 0);
    check_output("rd1_t2_valid", 32'(inst_valid), 0);
    check_output("rd1_t2_iaddr", 32'(iaddr), 32'h41);
    apply_stimulus(0, 1, 0, 0);
    check_output("rd1_t3_valid", 32'(inst_valid), 1);
    check_output("rd1_t3_pc", 32'(inst_pc), 32'h100);
    check_output("rd1_t3_inst", inst, 32'h40);
    apply_stimulus(0, 1, 0, 0);
    check_output("rd1_t4_pc", 32'(inst_pc), 32'h104);

    // Fill the queue, then redirect to a misaligned target while popping
    repeat (4) apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 1, 1, 12'h102);
    check_output("rd2_count", 32'(count), 4);
    check_output("rd2_ireq", 32'(ireq), 0);
    check_output("rd2_head", 32'(inst_pc), 32'h108);
    apply_stimulus(0, 1, 0, 0);
    check_output("rd2_t1_count", 32'(count), 0);
    check_output("rd2_t1_iaddr", 32'(iaddr), 32'h40);
    apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    check_output("rd2_t3_pc", 32'(inst_pc), 32'h100);

    // Address wrap
    apply_stimulus(0, 1, 1, 12'hFF8);
    apply_stimulus(0, 1, 0, 0);
    check_output("wrap_iaddr0", 32'(iaddr), 32'h3FE);
    apply_stimulus(0, 1, 0, 0);
    check_output("wrap_iaddr1", 32'(iaddr), 32'h3FF);
    apply_stimulus(0, 1, 0, 0);
    check_output("wrap_iaddr2", 32'(iaddr), 32'h000);
    check_output("wrap_pc0", 32'(inst_pc), 32'hFF8);
    check_output("wrap_inst0", inst, 32'h3FE);
    apply_stimulus(0, 1, 0, 0);
    check_output("wrap_pc1", 32'(inst_pc), 32'hFFC);
    apply_stimulus(0, 1, 0, 0);
    check_output("wrap_pc2", 32'(inst_pc), 32'h000);
    apply_stimulus(0, 1, 0, 0);
    check_output("wrap_pc3", 32'(inst_pc), 32'h004);

    // Mid-stream reset with two queued entries
    apply_stimulus(0, 0, 0, 0);
    check_output("mrst_pre_count", 32'(count), 1);
    apply_stimulus(1, 1, 0, 0);
    check_output("mrst_ireq", 32'(ireq), 0);
    check_output("mrst_valid", 32'(inst_valid), 0);
    check_output("mrst_count", 32'(count), 0);
    apply_stimulus(0, 1, 0, 0);
    check_output("mrst_r0_valid", 32'(inst_valid), 0);
    check_output("mrst_r0_count", 32'(count), 0);
    check_output("mrst_r0_ireq", 32'(ireq), 1);
    check_output("mrst_r0_iaddr", 32'(iaddr), 0);
    apply_stimulus(0, 1, 0, 0);
    check_output("mrst_r1_valid", 32'(inst_valid), 0);
    apply_stimulus(0, 1, 0, 0);
    check_output("mrst_r2_valid", 32'(inst_valid), 1);
    check_output("mrst_r2_pc", 32'(inst_pc), 0);
    check_output("mrst_r2_inst", inst, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Parametrised instruction-fetch front end for the five-stage pipelined core. It replaces the bare PC register and IF/ID latch with four pieces: a PC generator, a registered-ROM request engine, a DEPTH-entry prefetch queue, and a valid/ready handshake to decode. It also adds features the single-latch fetch path lacks: decode backpressure, and a branch redirect that flushes queued and in-flight instructions.

## Interface
- DATA_SIZE, 32, instruction width
- ADDR_SIZE, 10, instruction-memory word-address width; PCs are ADDR_SIZE+2 bits (byte addresses)
- DEPTH, 4, prefetch queue entries; power of two, >= 2
- RESET_PC, 0, byte address fetched first after reset
---
- CLK  in  1  clock; all state changes on its rising edge
- RESET  in  1  synchronous, active-high reset
- iaddr  out  ADDR_SIZE  word address to instruction ROM, equal to fetch_pc[ADDR_SIZE+1:2]
- ireq  out  1  fetch issued this cycle
- idata  in  DATA_SIZE  ROM data, valid the cycle after ireq (registered ROM)
- redirect  in  1  taken branch/jump; flush and restart
- redirect_pc  in  ADDR_SIZE+2  byte target of redirect
- inst_valid  out  1  queue head valid
- inst_ready  in  1  decode accepts head
- inst  out  DATA_SIZE  head instruction; 0 when !inst_valid
- inst_pc  out  ADDR_SIZE+2  head PC; 0 when !inst_valid
- count  out  $clog2(DEPTH+1)  queue occupancy

## Operation
- **State**
  - fetch_pc: ADDR_SIZE+2 bits.
  - inflight_q: 1 bit, set to the previous cycle's ireq.
  - pc_q: PC of the in-flight request.
  - Circular queue with rd/wr pointers and count.
- **pop** = inst_valid && inst_ready.
- **Issue:** ireq = !RESET && !redirect && (count + inflight_q - pop < DEPTH).
  - ireq combinationally depends on inst_ready.
  - On issue: fetch_pc <= fetch_pc + 4, wrapping modulo 2^(ADDR_SIZE+2).
  - At the same time: pc_q <= fetch_pc and inflight_q <= 1.
  - Otherwise inflight_q <= 0.
- **Response:** when inflight_q && !redirect, push {idata, pc_q} at the write pointer.
  - The issue rule guarantees the queue never overflows.
- **Head:** inst_valid = (count != 0). The head is read from registered storage; there is no bypass from idata.
- **Counting:** push and pop in the same cycle leaves count unchanged. Pointers wrap modulo DEPTH.
- **Redirect (highest priority after RESET):**
  - count, rd and wr <= 0; inflight_q <= 0, so a response arriving in the next cycle is discarded.
  - fetch_pc <= {redirect_pc[ADDR_SIZE+1:2], 2'b00}; misaligned low bits are dropped.
  - No issue or push in the redirect cycle. A pop shown to decode in that cycle is decode's responsibility to squash.
- **Reset:**
  - fetch_pc <= RESET_PC; count, pointers and inflight_q <= 0.
  - Outputs during and after reset: ireq=0, inst_valid=0, inst=0, inst_pc=0, count=0, iaddr=RESET_PC[ADDR_SIZE+1:2].
  - Reset mid-operation drops all queued and in-flight instructions.

## Timing
- **Cold start:** RESET falls before cycle 0. Cycle 0: ireq=1, iaddr=RESET_PC>>2. Cycle 1: idata is pushed. Cycle 2: inst_valid=1.
- **Fetch-to-decode latency:** 2 cycles.
- **Throughput:** with inst_ready held high, one instruction per cycle in steady state for any DEPTH >= 2.
- **Redirect at cycle t:**
  - Cycle t+1: ireq=1, iaddr=redirect_pc>>2.
  - Cycle t+3: inst_valid=1 with inst_pc=redirect_pc.
  - inst_valid=0 during cycles t+1 and t+2.
- **Backpressure:** with inst_ready=0 the queue fills to DEPTH and ireq drops. After inst_ready rises, ireq reasserts in the same cycle as the first pop.

## Test plan
- **Cold start:** reset with RESET_PC=0, ROM word n = n, inst_ready=1. Required: inst_valid from cycle 2; inst=0,1,2,… with inst_pc=0,4,8,… on consecutive cycles; count settles at 1.
- **Backpressure:** inst_ready=0 from cycle 0, DEPTH=4. Required: count reaches 4, ireq=0 thereafter, no entry lost. Release inst_ready. Required: inst 0,1,2,3 then 4 with no gap; ireq=1 in the release cycle.
- **Redirect with in-flight request:** pulse redirect with redirect_pc=0x100 while count=3 and inflight_q=1. Required: count=0 next cycle; stale response discarded; ireq with iaddr=0x40 one cycle after; inst_valid three cycles after with inst_pc=0x100.
- **Redirect with pop and full queue:** pulse redirect with redirect_pc=0x102 while the queue is full and inst_ready=1. Required: queue empty, no issue in that cycle; fetch resumes at 0x100 (low bits dropped).
- **Address wrap:** ADDR_SIZE=10, redirect_pc=0xFF8. Required: inst_pc sequence 0xFF8, 0xFFC, 0x000, 0x004; iaddr 0x3FE, 0x3FF, 0x000.
- **Mid-stream reset:** assert RESET for 1 cycle while count=2. Required: next cycle inst_valid=0, count=0, ireq=0; after release, refetch starts from RESET_PC and the first valid instruction appears 2 cycles later.
